// File: rtl/dumbrv_stray_pkg.sv
// Shared types and constants for the stray peripheral bus bridge.
// Imported by the bridge, its interface users and testbenches.
package dumbrv_stray_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } stray_state_e;

    localparam logic [2:0] STRAY_SIZE_B = 3'd1;
    localparam logic [2:0] STRAY_SIZE_H = 3'd2;
    localparam logic [2:0] STRAY_SIZE_W = 3'd4;

    localparam logic [15:0] STRAY_GPIO_ADDR = 16'hFFFF;

    // Request fields captured on acceptance and replayed on the stray bus.
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic        uns;
        logic [31:0] data;
    } stray_req_t;

    function automatic logic stray_size_legal(input logic [2:0] size);
        return (size == STRAY_SIZE_B) || (size == STRAY_SIZE_H) || (size == STRAY_SIZE_W);
    endfunction

endpackage

// File: rtl/dumbrv_stray_bridge_if.sv
// Core request/response and stray bus signals of the bridge.
// slave is the bridge's view; master is the core-plus-peripherals view.
interface dumbrv_stray_bridge_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic [15:0] req_addr_i;
    logic [2:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_data_i;

    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;

    logic        stray_en_o;
    logic        stray_wr_o;
    logic [15:0] stray_addr_o;
    logic [2:0]  stray_size_o;
    logic [31:0] stray_data_o;
    logic [31:0] stray_data_i;
    logic        stray_done_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_size_i, req_unsigned_i, req_data_i,
        input  stray_data_i, stray_done_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output stray_en_o, stray_wr_o, stray_addr_o, stray_size_o, stray_data_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_size_i, req_unsigned_i, req_data_i,
        output stray_data_i, stray_done_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  stray_en_o, stray_wr_o, stray_addr_o, stray_size_o, stray_data_o
    );

endinterface

// File: rtl/dumbrv_load_ext.sv
// Combinational load-data extension: byte/halfword sign or zero extension to 32 bits.
// Also used by the core's RAM load path, so it stays free of bridge state.
module dumbrv_load_ext
    import dumbrv_stray_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic sign_b;
    logic sign_h;

    always_comb begin
        sign_b = data_i[7] & ~unsigned_i;
        sign_h = data_i[15] & ~unsigned_i;
        data_o = data_i;
        case (size_i)
            STRAY_SIZE_B: data_o = {{24{sign_b}}, data_i[7:0]};
            STRAY_SIZE_H: data_o = {{16{sign_h}}, data_i[15:0]};
            default:      data_o = data_i;
        endcase
    end

endmodule

// File: rtl/dumbrv_stray_bridge.sv
// Bridge from the core load/store unit to the stray peripheral bus: one request at a time,
// held on the bus until done or timeout, answered with a single registered response beat.
module dumbrv_stray_bridge
    import dumbrv_stray_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dumbrv_stray_bridge_if.slave bus
);

    localparam logic [TIMEOUT_W-1:0] CntLimit = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] CntOne   = TIMEOUT_W'(1);

    stray_state_e         state_q, state_d;
    stray_req_t           req_q, req_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          ext_data;

    dumbrv_load_ext u_load_ext (
        .data_i     (bus.stray_data_i),
        .size_i     (req_q.size),
        .unsigned_i (req_q.uns),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    req_d.wr   = bus.req_wr_i;
                    req_d.addr = bus.req_addr_i;
                    req_d.size = bus.req_size_i;
                    req_d.uns  = bus.req_unsigned_i;
                    req_d.data = bus.req_data_i;
                    if (stray_size_legal(bus.req_size_i)) begin
                        state_d = StAccess;
                    end else begin
                        // Illegal size never reaches the bus; answer straight away.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                if (bus.stray_done_i) begin
                    // Done beats a simultaneous timeout; stores respond with zero data.
                    if (!req_q.wr) begin
                        rdata_d = ext_data;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_d == CntLimit) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = (state_q == StIdle);
        bus.stray_en_o   = (state_q == StAccess);
        bus.stray_wr_o   = req_q.wr;
        bus.stray_addr_o = req_q.addr;
        bus.stray_size_o = req_q.size;
        bus.stray_data_o = req_q.data;
        bus.resp_valid_o = (state_q == StResp);
        bus.resp_data_o  = rdata_q;
        bus.resp_err_o   = err_q;
    end

endmodule
